memctrl: RTL and testbench

Memory bus controller for the multi-cycle MIPS core. It sits between the multi-cycle datapath/controller and a unified instruction/data memory that may take a variable number of cycles to respond. It turns the controller's single-cycle read/write requests into a req/ack handshake and raises `stall` to freeze the controller FSM until the access completes. It also reports misaligned accesses and memory timeouts as a sticky bus error.

---
 rtl/mips_pkg.sv | 42 ++++
 rtl/memtimer.sv | 41 ++++
 rtl/memctrl.sv | 113 +++++++++++
 tb/tb_memctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg : shared types and constants for the multi-cycle MIPS core  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } memstate_t;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEX   = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } ctrlstate_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   function automatic logic is_word_aligned(input logic [1:0] lsb);
      return lsb == 2'b00;
   endfunction

endpackage
`default_nettype wire

// File: rtl/memtimer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memtimer : counts REQ cycles and flags the last one allowed          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module memtimer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int            CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] TOP  = CW'(TIMEOUT);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (en && count_q != TOP)
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   // High during the TIMEOUT-th enabled cycle, when the count is about to reach TIMEOUT.
   assign expired = en && (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/memctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memctrl : req/ack memory bus controller with stall and sticky error  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module memctrl
   import mips_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             rd_req,
   input  logic             wr_req,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             done,
   output logic             stall,
   output logic             bus_err,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack
);

   memstate_t        state_q, state_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic             mem_we_q, mem_we_d;
   logic             req;
   logic             tmr_clr, tmr_en, tmr_expired;

   assign req = rd_req | wr_req;

   memtimer #(.TIMEOUT(TIMEOUT)) u_memtimer (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d     = state_q;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = mem_we_q;
      tmr_clr     = 1'b0;
      tmr_en      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               tmr_clr = 1'b1;
               if (is_word_aligned(addr[1:0])) begin
                  mem_addr_d  = addr;
                  mem_wdata_d = wdata;
                  mem_we_d    = wr_req;
                  state_d     = REQ;
               end else begin
                  state_d = ERR;
               end
            end
         end
         REQ: begin
            tmr_en = 1'b1;
            // An ack on the final allowed cycle still completes the access.
            if (mem_ack) begin
               if (!mem_we_q)
                  rdata_d = mem_rdata;
               state_d = DONE;
            end else if (tmr_expired) begin
               state_d = ERR;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
      end
   end

   assign rdata     = rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_req   = (state_q == REQ);
   assign done      = (state_q == DONE);
   assign bus_err   = (state_q == ERR);
   assign stall     = ((state_q == IDLE) && req) || (state_q == REQ) || (state_q == ERR);

endmodule
`default_nettype wire

// File: tb/tb_memctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_memctrl : directed scoreboard bench for memctrl (TIMEOUT = 4)     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_memctrl;

   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 4;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             rd_req = 1'b0, wr_req = 1'b0;
   logic [WIDTH-1:0] addr = '0, wdata = '0, mem_rdata = '0;
   logic             mem_ack = 1'b0;
   logic [WIDTH-1:0] rdata, mem_addr, mem_wdata;
   logic             done, stall, bus_err, mem_req, mem_we;

   int n_cmp = 0;
   int n_bad = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] model_rdata = '0;

   memctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .wr_req(wr_req),
      .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .stall(stall),
      .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Scoreboard monitor: every done pulse must match the oldest expected rdata.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            chk("sb_rdata", rdata, exp_q.pop_front());
         end
      end
   end

   task automatic access(input logic r, input logic w, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] md,
                         input int ack_k, input bit hold);
      rd_req = r; wr_req = w; addr = a; wdata = wd; mem_rdata = md;
      model_rdata = w ? model_rdata : md;
      exp_q.push_back(model_rdata);
      for (int c = 0; c <= ack_k + 1; c++) begin
         @(negedge clk);
         if (c == 0) begin
            chk("c0_stall", stall, 1);
            chk("c0_mem_req", mem_req, 0);
         end else if (c <= ack_k) begin
            chk("req_mem_req", mem_req, 1);
            chk("req_stall", stall, 1);
            chk("req_done", done, 0);
            chk("req_mem_we", mem_we, w);
            chk("req_mem_addr", mem_addr, a);
            if (w) chk("req_mem_wdata", mem_wdata, wd);
            mem_ack = (c == ack_k);
         end else begin
            chk("done_pulse", done, 1);
            chk("done_stall", stall, 0);
            chk("done_mem_req", mem_req, 0);
            chk("done_bus_err", bus_err, 0);
         end
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (c == ack_k + 1 && !hold) begin
            rd_req = 1'b0; wr_req = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      rd_req = 1'b0; wr_req = 1'b0; mem_ack = 1'b0;
      model_rdata = '0;
      #1;
      chk("rst_bus_err", bus_err, 0);
      chk("rst_mem_req", mem_req, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      // Reset values
      #3;
      chk("rst_rdata", rdata, 0);
      chk("rst_done", done, 0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_stall", stall, 0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;

      // Read, ack in first REQ cycle
      access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h8C08_0004, 1, 1'b0);
      @(posedge clk); #1;
      // Write, ack in the TIMEOUT-th REQ cycle: must still complete
      access(1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'h1111_1111, 4, 1'b0);
      chk("wr_rdata_kept", rdata, 32'h8C08_0004);
      // Simultaneous rd+wr (write wins), held through DONE, then back-to-back read
      access(1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 32'h2222_2222, 2, 1'b1);
      access(1'b1, 1'b0, 32'h0000_0034, 32'h0, 32'h3333_3333, 1, 1'b0);

      // Reset during REQ abandons the access
      rd_req = 1'b1; addr = 32'h0000_0044; mem_rdata = 32'h5555_5555;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_mem_req", mem_req, 1);
      #1 reset_n = 1'b0; rd_req = 1'b0;
      #1;
      chk("mid_rst_mem_req", mem_req, 0);
      chk("mid_rst_mem_addr", mem_addr, 0);
      chk("mid_rst_rdata", rdata, 0);
      chk("mid_rst_stall", stall, 0);
      model_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      access(1'b1, 1'b0, 32'h0000_0048, 32'h0, 32'hA5A5_A5A5, 2, 1'b0);

      // Misaligned read goes straight to ERR
      rd_req = 1'b1; addr = 32'h0000_0006;
      @(negedge clk);
      chk("mis_c0_stall", stall, 1);
      @(posedge clk); #1;
      rd_req = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk("mis_bus_err", bus_err, 1);
         chk("mis_mem_req", mem_req, 0);
         chk("mis_stall", stall, 1);
         @(posedge clk); #1;
      end
      do_reset();

      // Timeout: no ack, ERR in cycle TIMEOUT+1
      rd_req = 1'b1; addr = 32'h0000_0060;
      for (int c = 0; c <= TIMEOUT + 2; c++) begin
         @(negedge clk);
         if (c >= 1 && c <= TIMEOUT) begin
            chk("to_mem_req", mem_req, 1);
            chk("to_bus_err", bus_err, 0);
         end else if (c > TIMEOUT) begin
            chk("to_err_bus_err", bus_err, 1);
            chk("to_err_mem_req", mem_req, 0);
            chk("to_err_stall", stall, 1);
         end
         @(posedge clk); #1;
      end
      do_reset();

      repeat (2) @(posedge clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
